// File: rtl/lcd_pkg.sv
// lcd_pkg: shared states, command codes and bus bit positions for the LCD receiver
package lcd_pkg;
   typedef enum logic [1:0] {S_MODE8, S_HI, S_LO} state_t;
   localparam logic [7:0] CMD_CLEAR = 8'h01;
   localparam logic [7:0] CMD_HOME = 8'h02;
   localparam int LCD_E = 0;
   localparam int LCD_RW = 1;
   localparam int LCD_RS = 2;
   localparam logic [3:0] INIT_SWITCH_NIB = 4'h2;
endpackage

// File: rtl/lcd_char_ram.sv
// lcd_char_ram: character buffer with one synchronous write port and one registered read port
module lcd_char_ram #(
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [7:0]        wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [7:0]        rdata
);
   logic [7:0] mem [2**ADDR_W];
   always_ff @(posedge clk)
      if (we) mem[waddr] <= wdata;
   always_ff @(posedge clk)
      rdata <= rst ? 8'h00 : mem[raddr];
endmodule

// File: rtl/lcd_nibble_receiver.sv
// lcd_nibble_receiver: 4-bit LCD bus receiver that rebuilds bytes and mirrors characters into a buffer
module lcd_nibble_receiver
   import lcd_pkg::*;
#(
   parameter int ADDR_W = 5,
   parameter logic [7:0] CLEAR_CHAR = 8'h20
) (
   input  logic              clk_in,
   input  logic              clear,
   input  logic [3:0]        lcd_dataout,
   input  logic [2:0]        lcd_control,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [7:0]        rd_data,
   output logic              byte_valid,
   output logic [7:0]        byte_out,
   output logic              byte_rs,
   output logic [ADDR_W-1:0] cursor,
   output logic              mode4,
   output logic              busy,
   output logic              overrun
);
   state_t state_q, state_d;
   logic e_q, rw_q, rs_q, hi_rs_q, strobe, form;
   logic [3:0] nib_q, hi_q;
   logic [ADDR_W-1:0] fill_cnt;
   assign strobe = e_q & ~lcd_control[LCD_E] & ~rw_q;
   assign mode4 = state_q != S_MODE8;
   assign overrun = byte_valid & busy;
   always_ff @(posedge clk_in)
      state_q <= clear ? S_MODE8 : state_d;
   always_comb begin
      form = strobe & (state_q == S_LO);
      state_d = !strobe ? state_q
              : state_q == S_MODE8 ? (nib_q == INIT_SWITCH_NIB ? S_HI : S_MODE8)
              : state_q == S_HI ? S_LO : S_HI;
   end
   always_ff @(posedge clk_in) begin
      if (clear) begin
         e_q <= 1'b0;
         rw_q <= 1'b0;
         rs_q <= 1'b0;
         nib_q <= 4'h0;
         hi_q <= 4'h0;
         hi_rs_q <= 1'b0;
         byte_valid <= 1'b0;
         byte_out <= 8'h00;
         byte_rs <= 1'b0;
         cursor <= '0;
         busy <= 1'b0;
         fill_cnt <= '0;
      end else begin
         e_q <= lcd_control[LCD_E];
         rw_q <= lcd_control[LCD_RW];
         rs_q <= lcd_control[LCD_RS];
         nib_q <= lcd_dataout;
         if (strobe && state_q == S_HI) begin
            hi_q <= nib_q;
            hi_rs_q <= rs_q;
         end
         byte_valid <= form;
         if (form) begin
            byte_out <= {hi_q, nib_q};
            byte_rs <= hi_rs_q;
         end
         // bytes completing during a fill are reported but have no effect
         if (busy) begin
            fill_cnt <= fill_cnt + 1'b1;
            if (&fill_cnt) busy <= 1'b0;
         end else if (byte_valid) begin
            if (byte_rs) cursor <= cursor + 1'b1;
            else if (byte_out == CMD_CLEAR) begin
               cursor <= '0;
               busy <= 1'b1;
               fill_cnt <= '0;
            end else if (byte_out[7:1] == CMD_HOME[7:1]) cursor <= '0;
            else if (byte_out[7]) cursor <= ADDR_W'({byte_out[6], byte_out[3:0]});
         end
      end
   end
   lcd_char_ram #(.ADDR_W(ADDR_W)) u_ram (
      .clk(clk_in),
      .rst(clear),
      .we(busy | (byte_valid & byte_rs)),
      .waddr(busy ? fill_cnt : cursor),
      .wdata(busy ? CLEAR_CHAR : byte_out),
      .raddr(rd_addr),
      .rdata(rd_data)
   );
endmodule

// File: tb/tb_lcd_nibble_receiver.sv
// tb_lcd_nibble_receiver: directed checks of init handshake, byte assembly, commands and clear-fill
module tb_lcd_nibble_receiver;
   logic clk_in = 1'b0, clear = 1'b1;
   logic [3:0] lcd_dataout = 4'h0;
   logic [2:0] lcd_control = 3'b000;
   logic [4:0] rd_addr = 5'd0;
   logic [7:0] rd_data, byte_out;
   logic byte_valid, byte_rs, mode4, busy, overrun;
   logic [4:0] cursor;
   int n_cmp = 0, n_err = 0, bv_cnt = 0, ovr_cnt = 0, busy_cyc = 0;

   lcd_nibble_receiver dut (
      .clk_in(clk_in), .clear(clear), .lcd_dataout(lcd_dataout), .lcd_control(lcd_control),
      .rd_addr(rd_addr), .rd_data(rd_data), .byte_valid(byte_valid), .byte_out(byte_out),
      .byte_rs(byte_rs), .cursor(cursor), .mode4(mode4), .busy(busy), .overrun(overrun)
   );

   always #5 clk_in = ~clk_in;

   always @(negedge clk_in) begin
      if (byte_valid) bv_cnt++;
      if (overrun) ovr_cnt++;
      if (busy) busy_cyc++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic strobe(input logic [3:0] n, input logic rs, input logic rw);
      @(negedge clk_in);
      lcd_dataout = n;
      lcd_control = {rs, rw, 1'b1};
      @(negedge clk_in);
      lcd_control = {rs, rw, 1'b0};
      @(negedge clk_in);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic rs);
      strobe(b[7:4], rs, 1'b0);
      strobe(b[3:0], rs, 1'b0);
   endtask

   task automatic rd(input logic [4:0] a, output logic [7:0] d);
      @(negedge clk_in);
      rd_addr = a;
      @(negedge clk_in);
      d = rd_data;
   endtask

   task automatic do_reset();
      clear = 1'b1;
      repeat (3) @(negedge clk_in);
      clear = 1'b0;
   endtask

   initial begin
      logic [7:0] d;
      int bv0, guard;
      repeat (3) @(negedge clk_in);
      check("rst_bv", 32'(byte_valid), 0);
      check("rst_bo", 32'(byte_out), 0);
      check("rst_brs", 32'(byte_rs), 0);
      check("rst_cur", 32'(cursor), 0);
      check("rst_m4", 32'(mode4), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_ovr", 32'(overrun), 0);
      check("rst_rd", 32'(rd_data), 0);
      clear = 1'b0;
      strobe(4'h5, 1'b0, 1'b0);
      check("m4_after5", 32'(mode4), 0);
      strobe(4'h3, 1'b0, 1'b0);
      strobe(4'h3, 1'b0, 1'b0);
      strobe(4'h3, 1'b0, 1'b0);
      check("m4_after333", 32'(mode4), 0);
      strobe(4'h2, 1'b0, 1'b0);
      check("m4_after2", 32'(mode4), 1);
      check("init_nobyte", 32'(bv_cnt), 0);
      send_byte(8'h41, 1'b1);
      check("a_bv", 32'(byte_valid), 1);
      check("a_bo", 32'(byte_out), 32'h41);
      check("a_brs", 32'(byte_rs), 1);
      @(negedge clk_in);
      check("a_bv_pulse", 32'(byte_valid), 0);
      check("a_cur", 32'(cursor), 1);
      rd(5'd0, d);
      check("a_rd0", 32'(d), 32'h41);
      send_byte(8'hC5, 1'b0);
      @(negedge clk_in);
      check("c5_cur", 32'(cursor), 21);
      send_byte(8'h5A, 1'b1);
      @(negedge clk_in);
      check("5a_cur", 32'(cursor), 22);
      rd(5'd21, d);
      check("5a_rd21", 32'(d), 32'h5A);
      send_byte(8'hCF, 1'b0);
      @(negedge clk_in);
      check("cf_cur", 32'(cursor), 31);
      send_byte(8'h61, 1'b1);
      send_byte(8'h62, 1'b1);
      @(negedge clk_in);
      check("wrap_cur", 32'(cursor), 1);
      rd(5'd31, d);
      check("wrap_rd31", 32'(d), 32'h61);
      rd(5'd0, d);
      check("wrap_rd0", 32'(d), 32'h62);
      send_byte(8'h02, 1'b0);
      @(negedge clk_in);
      check("home_cur", 32'(cursor), 0);
      send_byte(8'hC3, 1'b0);
      @(negedge clk_in);
      busy_cyc = 0;
      ovr_cnt = 0;
      send_byte(8'h01, 1'b0);
      check("clr_bv", 32'(byte_valid), 1);
      check("clr_busy0", 32'(busy), 0);
      repeat (4) @(negedge clk_in);
      send_byte(8'h33, 1'b1);
      check("ovr_busy", 32'(busy), 1);
      guard = 0;
      while (busy && guard < 100) begin
         @(negedge clk_in);
         guard++;
      end
      check("busy_timeout", 32'(busy), 0);
      check("busy_cycles", 32'(busy_cyc), 32);
      check("ovr_count", 32'(ovr_cnt), 1);
      check("clr_cur", 32'(cursor), 0);
      for (int i = 0; i < 32; i++) begin
         rd(5'(i), d);
         check($sformatf("fill_%0d", i), 32'(d), 32'h20);
      end
      send_byte(8'h4B, 1'b1);
      @(negedge clk_in);
      check("post_cur", 32'(cursor), 1);
      rd(5'd0, d);
      check("post_rd0", 32'(d), 32'h4B);
      strobe(4'h4, 1'b1, 1'b0);
      strobe(4'hF, 1'b0, 1'b1);
      strobe(4'h2, 1'b1, 1'b0);
      check("rw_bv", 32'(byte_valid), 1);
      check("rw_bo", 32'(byte_out), 32'h42);
      @(negedge clk_in);
      check("rw_cur", 32'(cursor), 2);
      strobe(4'h6, 1'b1, 1'b0);
      do_reset();
      check("mid_m4", 32'(mode4), 0);
      check("mid_cur", 32'(cursor), 0);
      bv0 = bv_cnt;
      strobe(4'h1, 1'b1, 1'b0);
      repeat (2) @(negedge clk_in);
      check("mid_nobyte", 32'(bv_cnt), 32'(bv0));
      check("mid_m4b", 32'(mode4), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end
endmodule

// File: doc/lcd_nibble_receiver.md
# lcd_nibble_receiver

Receive side of the HD44780-style 4-bit LCD bus driven by `mcu_single_cycle_lcd`. It samples `lcd_dataout`/`lcd_control`, follows the 8-bit-to-4-bit init handshake, and reassembles nibbles into command and data bytes. It decodes the basic cursor commands and mirrors written characters into a 32-entry display buffer, readable by a bench or a status peripheral. It sits on the same clock as the MCU and acts as the display model and bus checker.

## Interface

- `ADDR_W`, 5: buffer address width; 2 lines × 16 columns.
- `CLEAR_CHAR`, 8'h20: fill value used by the Clear Display command.
- `clk_in`  in  1  system clock; all logic on its rising edge.
- `clear`  in  1  reset, synchronous, active-high.
- `lcd_dataout`  in  4  LCD data nibble D7..D4.
- `lcd_control`  in  3  bit [0] = E, bit [1] = RW, bit [2] = RS.
- `rd_addr`  in  5  buffer read address.
- `rd_data`  out  8  buffer contents at `rd_addr`, registered.
- `byte_valid`  out  1  one-cycle pulse when a full byte is received.
- `byte_out`  out  8  last received byte; held until the next byte.
- `byte_rs`  out  1  RS value of `byte_out`.
- `cursor`  out  5  current write address.
- `mode4`  out  1  high once the 4-bit interface is established.
- `busy`  out  1  high while a clear-fill is in progress.
- `overrun`  out  1  one-cycle pulse when a byte is dropped because `busy` is high.

## Operation

- **Strobe detection.**
  - `lcd_control`/`lcd_dataout` are registered every cycle.
  - A strobe is the cycle where registered E = 1 and current E = 0 (falling edge).
  - The strobe uses the registered nibble, RS and RW.
  - Strobes with RW = 1 are reads. They are ignored and do not advance nibble phase.
- **States:** `S_MODE8`, `S_HI`, `S_LO`.
  - `S_MODE8`: each strobe is a single 8-bit-mode write. Nibble 4'h2 moves to `S_HI` and sets `mode4`. Any other nibble stays in `S_MODE8`. No byte is emitted.
  - `S_HI`: a strobe latches the upper nibble and RS, then moves to `S_LO`.
  - `S_LO`: a strobe forms the byte {hi, nibble}, pulses `byte_valid` and moves to `S_HI`. RS is taken from the high-nibble strobe.
- **Command decode** (byte_rs = 0, applied in the `byte_valid` cycle):
  - 8'h01 Clear: `cursor` ← 0, `busy` ← 1, fill runs.
  - 8'h02/8'h03 Home: `cursor` ← 0.
  - 8'b1xxx_xxxx Set DDRAM address: `cursor` ← {byte[6], byte[3:0]}; bits 5:4 are ignored.
  - All other commands: byte is emitted, no side effect.
- **Data** (byte_rs = 1): buffer[cursor] ← byte, then `cursor` ← `cursor` + 1 modulo 32 (31 wraps to 0).
- **Clear-fill:**
  - Writes `CLEAR_CHAR` to addresses 0..31, one per cycle.
  - `busy` is high for exactly 32 cycles.
  - Nibble assembly continues during the fill.
  - A completed byte during `busy` is still output on `byte_valid`/`byte_out`, but has no buffer or cursor effect, and `overrun` pulses in the same cycle.
- **Reset values** (from `clear`):
  - State `S_MODE8`; `mode4` = 0, `cursor` = 0, `busy` = 0.
  - `byte_valid` = 0, `overrun` = 0, `byte_out` = 8'h00, `byte_rs` = 0, `rd_data` = 8'h00.
  - Buffer contents are not reset.
- **Reset mid-operation:** a half-received byte is discarded, and a running fill aborts immediately with partial contents left as-is.

## Timing

- `byte_valid` is asserted 1 cycle after the cycle in which E is sampled low.
- A buffer write is visible on `rd_data` 2 cycles after `byte_valid`: 1 cycle for the write, 1 for the registered read.
- `rd_data` has a 1-cycle latency from `rd_addr`. Same-address read and write in one cycle returns old data.
- Clear: `busy` rises in the cycle after `byte_valid` and falls 32 cycles later. A data byte completing in the first non-busy cycle is accepted.
- E must be high for at least 1 cycle and low for at least 1 cycle. An E pulse shorter than 1 cycle is not detected.

## Structure

- Package `lcd_pkg`:
  - State encoding `S_MODE8`/`S_HI`/`S_LO`.
  - Command constants `CMD_CLEAR` = 8'h01, `CMD_HOME` = 8'h02.
  - `LCD_E`, `LCD_RW`, `LCD_RS` bit indices.
  - `INIT_SWITCH_NIB` = 4'h2.
- Sub-module `lcd_char_ram`: 32×8, one synchronous write port and one registered read port.

## Test plan

- Init 3,3,3,2 strobes → no `byte_valid`, `mode4` = 1 after the 4th strobe. A preceding 4'h5 strobe leaves `mode4` = 0.
- Init, then RS = 1 nibbles 4'h4, 4'h1 → `byte_valid` pulse, `byte_out` = 8'h41, `byte_rs` = 1, `cursor` = 1; `rd_addr` = 0 reads 8'h41.
- Command 8'hC5 then data 8'h5A → `cursor` = 21 before the write; buffer[21] = 8'h5A; `cursor` = 22 after.
- Set address to 8'hCF, write 2 bytes → bytes land at 31 and 0; `cursor` = 1.
- Command 8'h01 with a data byte completed 10 cycles later → `busy` high for 32 cycles, `overrun` pulses once, all 32 entries read 8'h20, `cursor` = 0.
- RW = 1 strobes interleaved between nibbles, plus `clear` asserted between the high and low nibble → reads are ignored; after reset the state is `S_MODE8` and no byte is emitted.
